// File: rtl/keypad_pkg.sv
// Shared types, widths and helpers for the keypad event controller.
package keypad_pkg;

  localparam int unsigned KEY_W         = 16;
  localparam int unsigned CODE_W        = 4;
  localparam int unsigned EVT_W         = 5;
  // Event bit that distinguishes press (1) from release (0).
  localparam int unsigned EVT_PRESS_BIT = 4;
  localparam int unsigned CNT_W         = 8;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } kp_state_e;

  // True when exactly one bit of the active-low key vector is low.
  function automatic logic is_single_low(input logic [KEY_W-1:0] key);
    logic [KEY_W-1:0] v;
    v = ~key;
    return (v != '0) && ((v & (v - KEY_W'(1))) == '0);
  endfunction

  // Index of the low bit of a one-hot-low key vector.
  function automatic logic [CODE_W-1:0] onehot_low_to_code(input logic [KEY_W-1:0] key);
    logic [CODE_W-1:0] code;
    code = '0;
    for (int unsigned i = 0; i < KEY_W; i++) begin
      if (!key[i]) code = CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Event queue: power-of-two depth FIFO with combinational head output.
module keypad_evt_fifo
  import keypad_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = EVT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_drop
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_do_push;
  logic w_do_pop;

  // Push/pop qualification; a full queue still accepts a push when a pop frees a slot.
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    w_do_pop  = i_pop && !w_empty;
    w_do_push = i_push && (!w_full || w_do_pop);
    o_drop    = i_push && w_full && !w_do_pop;
    o_valid   = !w_empty;
    o_data    = w_empty ? '0 : r_mem[r_rptr];
  end

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_do_pop) r_rptr <= r_rptr + PTR_W'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/keypad_event_ctrl.sv
// Keypad debouncer: synchronizes the scanner, debounces single-key press/release
// and queues press/release events for a consumer.
module keypad_event_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [KEY_W-1:0]  key,
  input  logic              pressed,
  output logic              evt_valid,
  output logic [EVT_W-1:0]  evt_data,
  input  logic              evt_ready,
  output logic              held,
  output logic [CODE_W-1:0] held_code,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam logic [CNT_W-1:0] DB_TGT = CNT_W'(DEBOUNCE_CYCLES);

  logic [KEY_W-1:0]  r_key_s1, r_key_s2;
  logic              r_pressed_s1, r_pressed_s2;

  kp_state_e         r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [CODE_W-1:0] r_cand, w_cand_nxt;
  logic [CODE_W-1:0] r_held_code, w_held_code_nxt;
  logic              r_overflow;

  logic              w_valid_single;
  logic [CODE_W-1:0] w_code;
  logic              w_push;
  logic [EVT_W-1:0]  w_push_data;
  logic              w_pop;
  logic              w_drop;

  // Two-flop synchronizer; idle value is "no key, not pressed".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_s1     <= '1;
      r_key_s2     <= '1;
      r_pressed_s1 <= 1'b0;
      r_pressed_s2 <= 1'b0;
    end else begin
      r_key_s1     <= key;
      r_key_s2     <= r_key_s1;
      r_pressed_s1 <= pressed;
      r_pressed_s2 <= r_pressed_s1;
    end
  end

  // Sample classification and saturating counter increment.
  always_comb begin
    w_valid_single = r_pressed_s2 && is_single_low(r_key_s2);
    w_code         = onehot_low_to_code(r_key_s2);
    w_cnt_inc      = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  end

  // Debounce FSM next-state and event generation.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_cand_nxt      = r_cand;
    w_held_code_nxt = r_held_code;
    w_push          = 1'b0;
    w_push_data     = '0;
    unique case (r_state)
      StIdle: begin
        if (w_valid_single) begin
          w_cand_nxt  = w_code;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = StPressWait;
        end
      end
      StPressWait: begin
        if (w_valid_single && (w_code == r_cand)) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= DB_TGT) begin
            w_push                      = 1'b1;
            w_push_data[EVT_PRESS_BIT]  = 1'b1;
            w_push_data[CODE_W-1:0]     = r_cand;
            w_held_code_nxt             = r_cand;
            w_cnt_nxt                   = '0;
            w_state_nxt                 = StHeld;
          end
        end else if (w_valid_single) begin
          w_cand_nxt = w_code;
          w_cnt_nxt  = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
        end
      end
      StHeld: begin
        // Key-bit changes are ignored here: no rollover.
        if (!r_pressed_s2) begin
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = StReleaseWait;
        end
      end
      StReleaseWait: begin
        if (!r_pressed_s2) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc >= DB_TGT) begin
            w_push                  = 1'b1;
            w_push_data[CODE_W-1:0] = r_held_code;
            w_cnt_nxt               = '0;
            w_state_nxt             = StIdle;
          end
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = StHeld;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = StIdle;
      end
    endcase
  end

  // FSM state and debounce bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_held_code <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cand      <= w_cand_nxt;
      r_held_code <= w_held_code_nxt;
    end
  end

  // Sticky overflow; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Output decode.
  always_comb begin
    w_pop     = evt_valid && evt_ready;
    held      = (r_state == StHeld) || (r_state == StReleaseWait);
    held_code = r_held_code;
    overflow  = r_overflow;
  end

  keypad_evt_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (EVT_W)
  ) u_evt_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_valid (evt_valid),
    .o_data  (evt_data),
    .o_drop  (w_drop)
  );

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Directed bench for keypad_event_ctrl with default parameters (debounce 20, depth 4).
module tb_keypad_event_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] key;
  logic        pressed;
  logic        evt_valid;
  logic [4:0]  evt_data;
  logic        evt_ready;
  logic        held;
  logic [3:0]  held_code;
  logic        overflow;
  logic        ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  keypad_event_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .pressed   (pressed),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ready (evt_ready),
    .held      (held),
    .held_code (held_code),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [4:0] exp);
    chk({tag, "_valid"}, 16'(evt_valid), 16'h1);
    chk({tag, "_data"}, 16'(evt_data), 16'(exp));
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
  endtask

  task automatic press(input int c);
    key     = ~(16'h0001 << c);
    pressed = 1'b1;
    cyc(25);
  endtask

  task automatic release_key();
    pressed = 1'b0;
    cyc(25);
  endtask

  initial begin
    reset     = 1'b0;
    key       = 16'hFFFF;
    pressed   = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    cyc(2);

    // Reset values
    chk("rst_valid", 16'(evt_valid), 16'h0);
    chk("rst_data", 16'(evt_data), 16'h0);
    chk("rst_held", 16'(held), 16'h0);
    chk("rst_code", 16'(held_code), 16'h0);
    chk("rst_ovf", 16'(overflow), 16'h0);
    reset = 1'b1;
    cyc(3);
    chk("idle_valid", 16'(evt_valid), 16'h0);

    // Clean press of key 5: 2 sync + 20 debounce cycles -> visible after 22 edges
    key     = ~16'h0020;
    pressed = 1'b1;
    cyc(21);
    chk("press5_early", 16'(evt_valid), 16'h0);
    chk("press5_early_held", 16'(held), 16'h0);
    cyc(1);
    chk("press5_held", 16'(held), 16'h1);
    chk("press5_code", 16'(held_code), 16'h5);
    pop_chk("press5", 5'h15);
    chk("press5_single", 16'(evt_valid), 16'h0);

    // Key change while held is ignored
    key = ~16'h0008;
    cyc(6);
    chk("rollover_code", 16'(held_code), 16'h5);
    chk("rollover_valid", 16'(evt_valid), 16'h0);

    // Release of key 5 with exact timing
    pressed = 1'b0;
    cyc(10);
    chk("rel5_mid_held", 16'(held), 16'h1);
    cyc(11);
    chk("rel5_early", 16'(evt_valid), 16'h0);
    cyc(1);
    chk("rel5_held", 16'(held), 16'h0);
    pop_chk("rel5", 5'h05);

    // Bounce: pressed toggles every 5 cycles for 40 cycles, then steady
    key = ~16'h0080;
    for (int i = 0; i < 8; i++) begin
      pressed = (i % 2 == 0);
      cyc(5);
    end
    pressed = 1'b1;
    cyc(21);
    chk("bounce_early", 16'(evt_valid), 16'h0);
    cyc(1);
    pop_chk("bounce7", 5'h17);
    chk("bounce_single", 16'(evt_valid), 16'h0);
    release_key();
    pop_chk("bounce7_rel", 5'h07);

    // Release bounce on key 12 returns to held with no event
    press(12);
    chk("c_held", 16'(held), 16'h1);
    chk("c_code", 16'(held_code), 16'hC);
    pressed = 1'b0;
    cyc(5);
    pressed = 1'b1;
    cyc(25);
    chk("c_bounce_held", 16'(held), 16'h1);
    release_key();
    chk("c_rel_held", 16'(held), 16'h0);
    pop_chk("c_press", 5'h1C);
    pop_chk("c_rel", 5'h0C);
    chk("c_empty", 16'(evt_valid), 16'h0);

    // Overflow: 6 events into a depth-4 queue with no consumer
    for (int c = 1; c <= 3; c++) begin
      press(c);
      release_key();
    end
    chk("ovf_set", 16'(overflow), 16'h1);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", 16'(overflow), 16'h0);
    // Clear coinciding with a new drop: set wins
    key     = ~16'h0020;
    pressed = 1'b1;
    cyc(21);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_setwins", 16'(overflow), 16'h1);
    cyc(3);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    chk("ovf_clr2", 16'(overflow), 16'h0);
    pop_chk("ovf_q0", 5'h11);
    pop_chk("ovf_q1", 5'h01);
    pop_chk("ovf_q2", 5'h12);
    pop_chk("ovf_q3", 5'h02);
    chk("ovf_empty", 16'(evt_valid), 16'h0);
    release_key();
    pop_chk("ovf_rel5", 5'h05);

    // Full queue with a pop in the push cycle: nothing dropped, order kept
    press(4);
    release_key();
    press(6);
    release_key();
    chk("full_ovf0", 16'(overflow), 16'h0);
    key     = ~16'h0200;
    pressed = 1'b1;
    cyc(21);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    chk("full_pp_ovf", 16'(overflow), 16'h0);
    pop_chk("full_q0", 5'h04);
    pop_chk("full_q1", 5'h16);
    pop_chk("full_q2", 5'h06);
    chk("full_q3_valid", 16'(evt_valid), 16'h1);
    chk("full_q3_data", 16'(evt_data), 16'h19);

    // Reset mid-hold with an event still queued
    reset = 1'b0;
    #1;
    chk("rhold_valid", 16'(evt_valid), 16'h0);
    chk("rhold_data", 16'(evt_data), 16'h0);
    chk("rhold_held", 16'(held), 16'h0);
    chk("rhold_code", 16'(held_code), 16'h0);
    pressed = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(30);
    chk("rhold_noevt", 16'(evt_valid), 16'h0);

    // Reset in press-wait at cnt=10
    key     = ~16'h0400;
    pressed = 1'b1;
    cyc(12);
    reset = 1'b0;
    #1;
    chk("rpw_valid", 16'(evt_valid), 16'h0);
    chk("rpw_held", 16'(held), 16'h0);
    chk("rpw_ovf", 16'(overflow), 16'h0);
    pressed = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(30);
    chk("rpw_noevt", 16'(evt_valid), 16'h0);
    chk("rpw_noheld", 16'(held), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_event_ctrl.md
KEYPAD_EVENT_CTRL -- requirements
Module: keypad_event_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20: clk cycles of stable input required to accept a press or release; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: event queue entries; power of two, 2..16.
REQ-003 clk  input  1  system clock; one clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 key  input  16  scanner key vector, active-low one-hot; bit n low means key n; holds last value after release.
REQ-006 pressed  input  1  scanner any-key-down flag, active-high.
REQ-007 evt_valid  output  1  queue head holds an event.
REQ-008 evt_data  output  5  event: bit4 = 1 press / 0 release, bits3:0 = key code 0..15.
REQ-009 evt_ready  input  1  consumer accepts head when evt_valid && evt_ready at posedge clk.
REQ-010 held  output  1  a debounced key is currently down.
REQ-011 held_code  output  4  code of the debounced held key; valid while held=1.
REQ-012 overflow  output  1  sticky: an event was dropped because the queue was full.
REQ-013 ovf_clr  input  1  single-cycle pulse that clears overflow.

Function
REQ-014 key and pressed pass through a 2-flop synchronizer before use; this adds 2 cycles of latency.
REQ-015 A synchronized sample is "valid-single" when pressed=1 and exactly one key bit is 0; code = index of that bit.
REQ-016 FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-017 IDLE: on valid-single, latch cand=code, load cnt=1, go to PRESS_WAIT; otherwise stay.
REQ-018 PRESS_WAIT, on valid-single with code==cand: cnt++; when cnt reaches DEBOUNCE_CYCLES, push {1,cand}, set held_code=cand, go to HELD.
REQ-019 PRESS_WAIT, on valid-single with code!=cand: cand=code, cnt=1, stay.
REQ-020 PRESS_WAIT, on pressed=0 or a multi-key sample: go to IDLE with no event.
REQ-021 HELD: while pressed=1, stay; any key-bit change while held is ignored (no rollover). On pressed=0, go to RELEASE_WAIT with cnt=1.
REQ-022 RELEASE_WAIT, on pressed=0: cnt++; when cnt reaches DEBOUNCE_CYCLES, push {0,held_code} and go to IDLE.
REQ-023 RELEASE_WAIT, on pressed=1: return to HELD with no event (bounce).
REQ-024 held=1 exactly in HELD and RELEASE_WAIT.
REQ-025 Queue is FIFO, depth FIFO_DEPTH; evt_data shows the head combinationally from storage and is 0 when empty; evt_valid = not empty.
REQ-026 Push latency: an event is visible on evt_valid the cycle after the FSM push cycle.
REQ-027 Empty queue: a pop attempt is ignored, pointers unchanged.
REQ-028 Full queue, push only: the event is dropped and overflow is set next cycle.
REQ-029 Full queue, push and pop in the same cycle: both are performed, nothing is dropped, count is unchanged.
REQ-030 Pointers wrap modulo FIFO_DEPTH; occupancy count is width clog2(FIFO_DEPTH)+1.
REQ-031 ovf_clr in the same cycle as a new overflow: overflow remains 1 (set wins).
REQ-032 Counter cnt is 8 bits and saturates; no wrap.

Reset
REQ-033 reset low asynchronously forces: FSM=IDLE, cnt=0, cand=0, held_code=0, synchronizer flops to key=16'hFFFF and pressed=0, queue empty, evt_valid=0, evt_data=0, held=0, overflow=0.
REQ-034 reset mid-debounce or mid-hold discards all pending and queued events; no release event is generated.
REQ-035 Reset deassertion is synchronized to clk by the integrating top level; this block treats release as synchronous.

Structure
REQ-036 Shared package keypad_pkg holds: the FSM state enum, EVT_W=5, CODE_W=4, the press/release bit position, and the one-hot-low-to-code encode function.
REQ-037 The queue is a sub-module keypad_evt_fifo (parameter FIFO_DEPTH, data width EVT_W), instanced once.

Verification
REQ-038 Clean press: key=~16'h0020 with pressed=1 held for 25 cycles -> exactly one event 5'b1_0101, held=1, held_code=5.
REQ-039 Bounce: pressed toggles every 5 cycles for 40 cycles, then is held steady -> one press event only, issued DEBOUNCE_CYCLES after the toggling stops.
REQ-040 Release: from HELD on code 0xC, pressed=0 for 25 cycles -> event 5'b0_1100, then held=0.
REQ-041 Overflow: evt_ready=0 while 3 press/release pairs occur (6 events) -> the queue holds the first 4, overflow=1; ovf_clr pulse -> overflow=0.
REQ-042 Full queue with evt_ready=1 in the same cycle as a push -> no drop, overflow stays 0, order preserved.
REQ-043 reset asserted in PRESS_WAIT at cnt=10 -> all outputs at reset values, and no event after release.
